// File: rtl/split_sample_gen.sv
// split_sample_gen: LFSR-driven candidate generator for a split constraint checker.
// Builds a VEC_W-bit candidate 32 bits per cycle, presents it to the checker,
// and keeps regenerating until the checker accepts or the retry limit is hit.
// Optional statistics counters are compiled in with SPLIT_SAMPLE_GEN_STATS_EN.
module split_sample_gen #(
   parameter int unsigned VEC_W     = 64,
   parameter int unsigned MAX_TRIES = 255,
   parameter int unsigned TRY_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [31:0]      seed,
   input  logic             start,
   output logic [VEC_W-1:0] cand_vec,
   input  logic             chk_x,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [VEC_W-1:0] sample_data,
   output logic             busy,
   output logic             fail,
   output logic [TRY_W-1:0] try_count
`ifdef SPLIT_SAMPLE_GEN_STATS_EN
   ,
   output logic [15:0]      accept_cnt,
   output logic [15:0]      reject_cnt
`endif
);

   localparam int unsigned NCHUNK = (VEC_W + 31) / 32;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [31:0]      LfsrMask  = 32'h8020_0003;
   localparam logic [CW-1:0]    LastChunk = CW'(NCHUNK - 1);
   localparam logic [TRY_W-1:0] MaxTry    = TRY_W'(MAX_TRIES);

   typedef enum logic [2:0] {
      StIdle,
      StGen,
      StCheck,
      StOut,
      StFail
   } state_e;

   state_e                  state_q;
   logic [31:0]             lfsr_q;
   logic [31:0]             lfsr_step;
   logic [31:0]             seed_val;
   logic [CW-1:0]           chunk_q;
   logic [NCHUNK*32-1:0]    cand_q;
   logic [TRY_W-1:0]        try_inc;

   // Next Galois LFSR state, seed sanitising and the incremented retry count.
   always_comb begin
      lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'h0);
      seed_val  = (seed == 32'h0) ? 32'h1 : seed;
      try_inc   = try_count + 1'b1;
   end

   // Only the low VEC_W bits reach the checker; excess bits of the last chunk are dropped.
   assign cand_vec = cand_q[VEC_W-1:0];

   // Main control FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         lfsr_q       <= 32'h1;
         chunk_q      <= '0;
         cand_q       <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         fail         <= 1'b0;
         try_count    <= '0;
      end else begin
         unique case (state_q)
            StIdle, StFail: begin
               // A seed loaded together with start is what the first GEN cycle sees.
               if (seed_load) begin
                  lfsr_q <= seed_val;
               end
               if (start) begin
                  state_q   <= StGen;
                  chunk_q   <= '0;
                  try_count <= '0;
                  fail      <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            StGen: begin
               for (int unsigned k = 0; k < NCHUNK; k++) begin
                  if (chunk_q == CW'(k)) begin
                     cand_q[32*k +: 32] <= lfsr_q;
                  end
               end
               lfsr_q <= lfsr_step;
               if (chunk_q == LastChunk) begin
                  state_q <= StCheck;
               end else begin
                  chunk_q <= chunk_q + 1'b1;
               end
            end
            StCheck: begin
               if (chk_x) begin
                  sample_data  <= cand_q[VEC_W-1:0];
                  sample_valid <= 1'b1;
                  state_q      <= StOut;
               end else if (try_inc == MaxTry) begin
                  try_count <= MaxTry;
                  fail      <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= StFail;
               end else begin
                  try_count <= try_inc;
                  chunk_q   <= '0;
                  state_q   <= StGen;
               end
            end
            StOut: begin
               if (sample_ready) begin
                  sample_valid <= 1'b0;
                  busy         <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef SPLIT_SAMPLE_GEN_STATS_EN
   // Saturating accept/reject counters, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_cnt <= '0;
         reject_cnt <= '0;
      end else begin
         if (state_q == StOut && sample_ready && accept_cnt != 16'hFFFF) begin
            accept_cnt <= accept_cnt + 16'd1;
         end
         if (state_q == StCheck && !chk_x && reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_split_sample_gen.sv
// Testbench for split_sample_gen: directed scenarios plus randomized requests,
// checked against a request-level model of the candidate sequence.
// Stats ports are exercised when SPLIT_SAMPLE_GEN_STATS_EN is defined.
module tb_split_sample_gen;

   localparam int unsigned VEC_W = 64;
   localparam int unsigned MAXT  = 4;
   localparam int unsigned TRY_W = 8;
   localparam int unsigned NCH   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             seed_load;
   logic [31:0]      seed;
   logic             start;
   logic [VEC_W-1:0] cand_vec;
   logic             chk_x;
   logic             sample_valid;
   logic             sample_ready;
   logic [VEC_W-1:0] sample_data;
   logic             busy;
   logic             fail;
   logic [TRY_W-1:0] try_count;
`ifdef SPLIT_SAMPLE_GEN_STATS_EN
   logic [15:0]      accept_cnt;
   logic [15:0]      reject_cnt;
`endif

   // Checker stand-in: selectable predicate on the candidate bus.
   int               chk_mode;
   logic [63:0]      target;
   logic [63:0]      rmask;

   // Reference state and bookkeeping.
   logic [31:0]      m_lfsr;
   int               m_acc;
   int               m_rej;
   logic [63:0]      last_data;
   int               n_checks;
   int               n_pass;

   split_sample_gen #(
      .VEC_W    (VEC_W),
      .MAX_TRIES(MAXT),
      .TRY_W    (TRY_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seed_load   (seed_load),
      .seed        (seed),
      .start       (start),
      .cand_vec    (cand_vec),
      .chk_x       (chk_x),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sample_data (sample_data),
      .busy        (busy),
      .fail        (fail),
      .try_count   (try_count)
`ifdef SPLIT_SAMPLE_GEN_STATS_EN
      ,
      .accept_cnt  (accept_cnt),
      .reject_cnt  (reject_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit model_chk(input logic [63:0] v);
      case (chk_mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return v == target;
         default: return ^(v & rmask);
      endcase
   endfunction

   always_comb begin
      chk_x = model_chk(cand_vec);
   end

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [32:0] wide;
      wide = {1'b0, s};
      // Galois form of x^32+x^22+x^2+x+1: shift right, fold taps on bit-0 out.
      if (s[0]) return (s >> 1) ^ 32'h8020_0003;
      return wide[32:1];
   endfunction

   // Candidate number idx produced from LFSR state s (two consecutive states per candidate).
   function automatic logic [63:0] cand_at(input logic [31:0] s, input int idx);
      logic [31:0] c0;
      logic [31:0] c1;
      logic [31:0] st;
      st = s;
      c0 = '0;
      c1 = '0;
      for (int i = 0; i <= idx; i++) begin
         c0 = st;
         st = lfsr_next(st);
         c1 = st;
         st = lfsr_next(st);
      end
      return {c1, c0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Request-level model: walk candidates until accept or retry limit.
   task automatic model_req(output logic [63:0] data, output int tries, output bit failed,
                            output int lat);
      logic [63:0] v;
      tries  = 0;
      failed = 1'b0;
      data   = '0;
      lat    = 0;
      forever begin
         v      = cand_at(m_lfsr, 0);
         m_lfsr = lfsr_next(lfsr_next(m_lfsr));
         if (model_chk(v)) begin
            data = v;
            lat  = NCH + 2 + tries * (NCH + 1);
            break;
         end else if (tries + 1 == MAXT) begin
            tries  = MAXT;
            failed = 1'b1;
            lat    = NCH + 2 + (MAXT - 1) * (NCH + 1);
            break;
         end
         tries++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "/cand_vec"}, cand_vec, 64'h0);
      check({tag, "/sample_data"}, sample_data, 64'h0);
      check({tag, "/sample_valid"}, {63'h0, sample_valid}, 64'h0);
      check({tag, "/busy"}, {63'h0, busy}, 64'h0);
      check({tag, "/fail"}, {63'h0, fail}, 64'h0);
      check({tag, "/try_count"}, {56'h0, try_count}, 64'h0);
   endtask

   // One request; latency counts edges including the one that samples start.
   task automatic run_req(input string tag, input bit with_seed, input logic [31:0] s,
                          input int ready_delay);
      logic [63:0] edata;
      int          etries;
      bit          efail;
      int          elat;
      int          cnt;
      if (with_seed) begin
         seed_load = 1'b1;
         seed      = s;
         m_lfsr    = (s == 32'h0) ? 32'h1 : s;
      end
      model_req(edata, etries, efail, elat);
      start = 1'b1;
      tick();
      start     = 1'b0;
      seed_load = 1'b0;
      cnt       = 1;
      check({tag, "/busy_after_start"}, {63'h0, busy}, 64'h1);
      check({tag, "/fail_cleared"}, {63'h0, fail}, 64'h0);
      while (!sample_valid && !fail && cnt < 1000) begin
         tick();
         cnt++;
      end
      check({tag, "/latency"}, 64'(cnt), 64'(elat));
      check({tag, "/try_count"}, {56'h0, try_count}, 64'(etries));
      check({tag, "/fail"}, {63'h0, fail}, {63'h0, efail});
      check({tag, "/busy"}, {63'h0, busy}, {63'h0, !efail});
      m_rej += etries;
      if (!efail) begin
         check({tag, "/data"}, sample_data, edata);
         last_data = sample_data;
         for (int i = 0; i < ready_delay; i++) begin
            start     = 1'b1;
            seed_load = 1'b1;
            seed      = $urandom;
            tick();
            start     = 1'b0;
            seed_load = 1'b0;
            check({tag, "/hold_valid"}, {63'h0, sample_valid}, 64'h1);
            check({tag, "/hold_data"}, sample_data, edata);
            check({tag, "/hold_cand"}, cand_vec, edata);
         end
         sample_ready = 1'b1;
         tick();
         sample_ready = 1'b0;
         m_acc++;
         check({tag, "/valid_dropped"}, {63'h0, sample_valid}, 64'h0);
         check({tag, "/idle_busy"}, {63'h0, busy}, 64'h0);
      end else begin
         repeat (2) tick();
         check({tag, "/fail_held"}, {63'h0, fail}, 64'h1);
         check({tag, "/fail_busy"}, {63'h0, busy}, 64'h0);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      m_acc        = 0;
      m_rej        = 0;
      m_lfsr       = 32'h1;
      last_data    = '0;
      chk_mode     = 1;
      target       = '0;
      rmask        = '1;
      rst_n        = 1'b0;
      seed_load    = 1'b0;
      seed         = '0;
      start        = 1'b0;
      sample_ready = 1'b0;
      #3;
      check_zero("reset");
      #9;
      rst_n = 1'b1;
      tick();

      // First-try accept from a zero seed loaded with start.
      chk_mode = 1;
      run_req("first", 1'b1, 32'h0, 0);
      check("first/const_data", last_data, 64'h8020_0003_0000_0001);

      // Three rejects, then accept.
      chk_mode = 2;
      target   = cand_at(m_lfsr, 3);
      run_req("rej3", 1'b0, 32'h0, 1);

      // Retry limit, then recovery from FAIL with a long ready stall.
      chk_mode = 0;
      run_req("limit", 1'b0, 32'h0, 0);
      chk_mode = 1;
      run_req("recover", 1'b0, 32'h0, 5);

      // Reset while generating.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      check_zero("rst_gen");
      rst_n = 1'b1;
      tick();

      // Reset while a sample is held.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("rst_out/pre_valid", {63'h0, sample_valid}, 64'h1);
      rst_n = 1'b0;
      #2;
      check_zero("rst_out");
      rst_n = 1'b1;
      m_lfsr = 32'h1;
      m_acc  = 0;
      m_rej  = 0;
      tick();
      run_req("after_rst", 1'b0, 32'h0, 0);
      check("after_rst/const_data", last_data, 64'h8020_0003_0000_0001);

      // Randomized requests against the model.
      chk_mode = 3;
      for (int i = 0; i < 12; i++) begin
         rmask = {32'($urandom), 32'($urandom)} | 64'h1;
         run_req("rand", ($urandom_range(0, 1) == 1), 32'($urandom), $urandom_range(0, 3));
      end

`ifdef SPLIT_SAMPLE_GEN_STATS_EN
      check("stats/accept_cnt", {48'h0, accept_cnt}, 64'(m_acc));
      check("stats/reject_cnt", {48'h0, reject_cnt}, 64'(m_rej));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
